serial_adder_seq: RTL and testbench

Bit-serial WIDTH-bit adder that sits directly downstream of the design's half-adder stage. It chains two half-adder cells and a carry flip-flop into a full adder, then feeds that adder one bit per clock. The two operands are shifted through LSB first, the result is reassembled in a shift register, and completion is signalled with a start/busy/done handshake. It exposes the live sum/carry bit stream for the parallel output pins.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_seq_if.sv | 26 ++
 rtl/serial_adder_seq_full_adder_cell.sv | 21 ++
 rtl/serial_adder_seq.sv | 108 ++++++++++
 tb/tb_serial_adder_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding and
// the helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/serial_adder_seq_if.sv
// Start/busy/done handshake, operand bus and live serial taps of serial_adder_seq.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             sum_bit;
    logic             carry_q;

    modport master (
        output start, op_a, op_b, sub,
        input  busy, done, sum, cout, sum_bit, carry_q
    );

    modport slave (
        input  start, op_a, op_b, sub,
        output busy, done, sum, cout, sum_bit, carry_q
    );

endinterface

// File: rtl/serial_adder_seq_full_adder_cell.sv
// One-bit full adder built from two half-adder stages; the serial adder's
// only arithmetic element.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;
    // Both half-adder carries can never be set together, so OR is exact.
    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    serial_adder_seq_if.slave bus
);
    import serial_adder_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt;
    logic               carry_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   b_init;
    logic               cin_init;

`ifdef SERIAL_ADDER_SUB_EN
    // A - B as A + ~B + 1: invert B once at capture and seed the carry with 1.
    assign b_init   = bus.sub ? ~bus.op_b : bus.op_b;
    assign cin_init = bus.sub;
`else
    logic sub_unused;
    assign sub_unused = bus.sub;
    assign b_init     = bus.op_b;
    assign cin_init   = 1'b0;
`endif

    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr    <= bus.op_a;
                        b_sr    <= b_init;
                        carry_q <= cin_init;
                        cnt     <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= fa_co;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        cout_q <= fa_co;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.carry_q = carry_q;
    assign bus.sum_bit = (state == RUN) ? fa_s : 1'b0;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed + randomized bench for serial_adder_seq against an arithmetic
// reference model (sum/carry computed with plain integer addition).
module tb_serial_adder_seq;

    localparam int W = 8;
    localparam int PERIOD = 10;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    time  last_done_t;

    serial_adder_seq_if #(.WIDTH(W)) bus ();

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: effective B operand and carry-in for a given sub request.
    function automatic int eff_b(input logic [W-1:0] b, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        return s ? int'((~b) & 8'hFF) : int'(b);
`else
        return int'(b);
`endif
    endfunction

    function automatic int eff_cin(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        return s ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
    endtask

    // Called at a negedge with start/operands already driven for this op.
    // pulse_mask bit i raises start during RUN cycle i (must be ignored).
    // chain: re-issue next op during the done cycle instead of going idle.
    task automatic run_op(input string name,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int pulse_mask, input bit chain, input bit check_gap,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
        int bv, cin, total, mask, cin_i;
        logic [31:0] exp_sum, exp_cout;
        bv       = eff_b(b, s);
        cin      = eff_cin(s);
        total    = int'(a) + bv + cin;
        exp_sum  = 32'(total & 8'hFF);
        exp_cout = 32'((total >> W) & 1);

        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        bus.sub   = 1'($urandom);
        for (int i = 1; i <= W; i++) begin
            mask  = (1 << (i - 1)) - 1;
            cin_i = ((int'(a) & mask) + (bv & mask) + cin) >> (i - 1);
            check({name, " busy"},    32'(bus.busy), 32'd1);
            check({name, " done"},    32'(bus.done), 32'd0);
            check({name, " sum_bit"}, 32'(bus.sum_bit), 32'(exp_sum[i-1]));
            check({name, " carry_q"}, 32'(bus.carry_q), 32'(cin_i & 1));
            bus.start = pulse_mask[i] ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        check({name, " done pulse"}, 32'(bus.done), 32'd1);
        check({name, " busy@done"},  32'(bus.busy), 32'd0);
        check({name, " sum"},        32'(bus.sum),  exp_sum);
        check({name, " cout"},       32'(bus.cout), exp_cout);
        check({name, " sum_bit@done"}, 32'(bus.sum_bit), 32'd0);
        if (check_gap)
            check({name, " done gap"}, 32'(($time - last_done_t) / PERIOD), 32'(W + 1));
        last_done_t = $time;
        if (chain) begin
            issue(na, nb, ns);
        end else begin
            bus.start = 1'b0;
            @(negedge clk);
            check({name, " done cleared"}, 32'(bus.done), 32'd0);
            check({name, " sum held"},     32'(bus.sum),  exp_sum);
            check({name, " cout held"},    32'(bus.cout), exp_cout);
        end
    endtask

    initial begin
        int seen_done;
        logic [W-1:0] ra, rb;
        logic rs;
        checks      = 0;
        errors      = 0;
        last_done_t = 0;

        // Reset with start asserted and random operands
        rst = 1'b1;
        issue(W'($urandom), W'($urandom), 1'($urandom));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy",    32'(bus.busy),    32'd0);
        check("rst done",    32'(bus.done),    32'd0);
        check("rst sum",     32'(bus.sum),     32'd0);
        check("rst cout",    32'(bus.cout),    32'd0);
        check("rst sum_bit", 32'(bus.sum_bit), 32'd0);
        check("rst carry_q", 32'(bus.carry_q), 32'd0);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle busy", 32'(bus.busy), 32'd0);

        // Plain add and full carry ripple
        issue(8'h5A, 8'h3C, 1'b0);
        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // start pulses during RUN cycles 3 and 5 are ignored
        issue(8'h10, 8'h20, 1'b0);
        run_op("busyign", 8'h10, 8'h20, 1'b0, (1 << 3) | (1 << 5), 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("busyign no restart", 32'(bus.busy), 32'd0);

        // Back-to-back with start held high
        issue(8'hA7, 8'h6B, 1'b0);
        run_op("b2b first", 8'hA7, 8'h6B, 1'b0, 'hFFFF, 1'b1, 1'b0, 8'h33, 8'hCD, 1'b0);
        run_op("b2b second", 8'h33, 8'hCD, 1'b0, 0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);

        // Reset asserted in RUN cycle 4 aborts without a done pulse
        issue(8'h37, 8'h55, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy",    32'(bus.busy),    32'd0);
        check("abort sum",     32'(bus.sum),     32'd0);
        check("abort carry_q", 32'(bus.carry_q), 32'd0);
        check("abort sum_bit", 32'(bus.sum_bit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done++;
        end
        check("abort no done", 32'(seen_done), 32'd0);
        issue(8'h01, 8'h01, 1'b0);
        run_op("post-abort", 8'h01, 8'h01, 1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Subtract requests (behave as plain add when the macro is off)
        issue(8'h10, 8'h01, 1'b1);
        run_op("sub1001", 8'h10, 8'h01, 1'b1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        issue(8'h00, 8'h01, 1'b1);
        run_op("sub0001", 8'h00, 8'h01, 1'b1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Randomized operations
        for (int k = 0; k < 8; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            issue(ra, rb, rs);
            run_op("random", ra, rb, rs, int'($urandom) & 'h1FE, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
